// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
// Widths are fixed at 32-bit operands and a 64-bit {remainder, quotient} result.
package div_pkg;

    localparam int REG_W  = 32;
    localparam int DREG_W = 64;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    // Magnitude of a 32-bit value, taken only when it is to be read as signed.
    function automatic logic [REG_W-1:0] abs_if(input logic [REG_W-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[REG_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Restoring shift-subtract divider: one quotient bit per clock, 33-cycle latency.
// Produces {remainder, quotient}; signed mode truncates toward zero.
module div
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o
);

    div_state_t        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [REG_W-1:0]  rem_q, rem_d;
    logic [REG_W-1:0]  quo_q, quo_d;
    logic [REG_W-1:0]  dvsr_q, dvsr_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [DREG_W-1:0] final_q, final_d;
    logic [DREG_W-1:0] result_d;
    logic              ready_d;

    // One restoring step: bring in the next dividend bit, keep the difference if non-negative.
    logic [REG_W:0]    shifted;
    logic [REG_W:0]    diff;
    logic              q_bit;

    assign shifted = {rem_q, quo_q[REG_W-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign q_bit   = ~diff[REG_W];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        final_d  = final_q;
        result_d = result_o;
        ready_d  = ready_o;

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = abs_if(opdata1_i, signed_div_i);
                        dvsr_d  = abs_if(opdata2_i, signed_div_i);
                        q_neg_d = signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                        r_neg_d = signed_div_i & opdata1_i[REG_W-1];
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d = DIV_END;
                final_d = '0;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q != DIV_ITERS) begin
                    rem_d = q_bit ? diff[REG_W-1:0] : shifted[REG_W-1:0];
                    quo_d = {quo_q[REG_W-2:0], q_bit};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    final_d[DREG_W-1:REG_W] = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                    final_d[REG_W-1:0]      = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                    result_d = final_d;
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end

            DIV_END: begin
                if (start_i == DIV_START) begin
                    result_d = final_q;
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            final_q  <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            final_q  <= final_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} from the arithmetic definition.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    // Issue one operation, hold start until ready, check latency, hold and release.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [63:0] exp;
        exp = ref_div(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (ready_o) break;
            lat++;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
        end
        check({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, "_res"}, result_o, exp);
        @(negedge clk);
        check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_clr"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        check("divu_100_7_model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("divz_u", 1'b0, 32'd1234, 32'd0);
        run_op("divz_s", 1'b1, 32'h8000_0001, 32'd0);

        // annul at E10 discards the operation
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_op("after_annul", 1'b0, 32'd9, 32'd3);

        // annul held in idle blocks acceptance
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul_idle_block", 64'(seen), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        // async reset mid-iteration
        @(negedge clk);
        opdata1_i = 32'd77;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_on", {63'd0, ready_o} | result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 1'b0, 32'd77, 32'd4);

        // async reset while a result is held clears the outputs without an edge
        @(negedge clk);
        opdata1_i = 32'd20;
        opdata2_i = 32'd6;
        start_i   = 1'b1;
        repeat (36) @(negedge clk);
        check("pre_rst_end", {ready_o, result_o[62:0]}, {1'b1, 63'({32'd2, 32'd3})});
        #2 rst = 1'b1;
        #1 check("rst_in_end", {63'd0, ready_o} | result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom);
            a   = $urandom;
            b   = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 3 == 0) b = b | 32'h8000_0000;
            run_op($sformatf("rand%0d", i), sgn, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
